freq_sweep_ctrl: RTL and testbench

Sweep sequencer that sits directly upstream of `single_freq_output` and drives its `freq`, `vpp` and `en` inputs. It steps the generator through a linear list of frequency points from `f_start` to `f_stop`. At each point it waits a settle time, then holds a measurement dwell window. It marks each window for downstream capture logic and reports completion with a start/busy/done handshake.

---
 rtl/freq_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/freq_sweep_ctrl.sv
// Linear frequency sweep sequencer driving single_freq_output: steps freq from
// f_start to f_stop, with a settle phase and a measurement dwell window per point.
module freq_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int DWELL_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        f_start,
    input  logic [15:0]        f_stop,
    input  logic [15:0]        f_step,
    input  logic [15:0]        vpp_set,
    input  logic [DWELL_W-1:0] dwell,
    output logic [15:0]        freq,
    output logic [15:0]        vpp,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               point_valid,
    output logic               meas_window,
    output logic [15:0]        point_idx
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0] dwell_last_q, dwell_last_d;
    logic [15:0]        f_stop_q, f_stop_d;
    logic [15:0]        f_step_q, f_step_d;

    logic [15:0] freq_q, freq_d;
    logic [15:0] vpp_q, vpp_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pv_q, pv_d;
    logic        mw_q, mw_d;
    logic [15:0] idx_q, idx_d;

    logic [16:0] nxt;

    // 17-bit sum so a carry out marks a step that would wrap past 16 bits
    assign nxt = {1'b0, freq_q} + {1'b0, f_step_q};

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        dwell_last_d = dwell_last_q;
        f_stop_d     = f_stop_q;
        f_step_d     = f_step_q;
        freq_d       = freq_q;
        vpp_d        = vpp_q;
        en_d         = en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pv_d         = 1'b0;
        mw_d         = mw_q;
        idx_d        = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    f_stop_d     = f_stop;
                    f_step_d     = f_step;
                    dwell_last_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                    freq_d       = f_start;
                    vpp_d        = vpp_set;
                    en_d         = 1'b1;
                    busy_d       = 1'b1;
                    idx_d        = 16'd0;
                    settle_cnt_d = 32'd0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    mw_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    dwell_cnt_d = '0;
                    pv_d        = 1'b1;
                    mw_d        = 1'b1;
                    state_d     = S_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q + 32'd1;
                end
            end
            S_DWELL: begin
                if (abort) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    mw_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (dwell_cnt_q == dwell_last_q) begin
                    mw_d = 1'b0;
                    if (f_step_q != 16'd0 && !nxt[16] && nxt[15:0] <= f_stop_q) begin
                        freq_d       = nxt[15:0];
                        idx_d        = idx_q + 16'd1;
                        settle_cnt_d = 32'd0;
                        state_d      = S_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        en_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= 32'd0;
            dwell_cnt_q  <= '0;
            dwell_last_q <= '0;
            f_stop_q     <= 16'd0;
            f_step_q     <= 16'd0;
            freq_q       <= 16'd0;
            vpp_q        <= 16'd0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pv_q         <= 1'b0;
            mw_q         <= 1'b0;
            idx_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            dwell_last_q <= dwell_last_d;
            f_stop_q     <= f_stop_d;
            f_step_q     <= f_step_d;
            freq_q       <= freq_d;
            vpp_q        <= vpp_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pv_q         <= pv_d;
            mw_q         <= mw_d;
            idx_q        <= idx_d;
        end
    end

    assign freq        = freq_q;
    assign vpp         = vpp_q;
    assign en          = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign point_valid = pv_q;
    assign meas_window = mw_q;
    assign point_idx   = idx_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl: directed and randomized sweeps compared
// cycle by cycle against a point-list / phase-arithmetic reference model.
module tb_freq_sweep_ctrl;

    localparam int S  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [15:0]   f_start, f_stop, f_step, vpp_set;
    logic [DW-1:0] dwell;
    logic [15:0]   freq, vpp, point_idx;
    logic          en, busy, done, point_valid, meas_window;

    int vectors = 0;
    int miscompares = 0;

    freq_sweep_ctrl #(.SETTLE_CYCLES(S), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .vpp_set(vpp_set),
        .dwell(dwell), .freq(freq), .vpp(vpp), .en(en), .busy(busy), .done(done),
        .point_valid(point_valid), .meas_window(meas_window), .point_idx(point_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (cycle +%0d): observed %0d, expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input int e_freq, input int e_vpp,
                           input int e_en, input int e_busy, input int e_done, input int e_pv,
                           input int e_mw, input int e_idx, input bit do_idx);
        chk({tag, ".freq"}, k, int'(freq), e_freq);
        chk({tag, ".vpp"},  k, int'(vpp),  e_vpp);
        chk({tag, ".en"},   k, int'(en),   e_en);
        chk({tag, ".busy"}, k, int'(busy), e_busy);
        chk({tag, ".done"}, k, int'(done), e_done);
        chk({tag, ".pv"},   k, int'(point_valid), e_pv);
        chk({tag, ".mw"},   k, int'(meas_window), e_mw);
        if (do_idx) chk({tag, ".idx"}, k, int'(point_idx), e_idx);
    endtask

    // abort_k / rst_k / xstart_k: cycle offset after start for that event, -1 = none,
    // -2 = pick a random offset within the sweep.
    task automatic run_sweep(input string name, input int fs, input int fstop, input int fstep,
                             input int vp, input int dw, input int abort_k, input int rst_k,
                             input int xstart_k);
        int pts[$];
        int p, n, np, per, total, hold_f, hold_v, hold_i;
        bit fin;
        pts.delete();
        p = fs;
        pts.push_back(p);
        forever begin
            if (fstep == 0) break;
            n = p + fstep;
            if (n > 65535 || n > fstop) break;
            p = n;
            pts.push_back(p);
        end
        np    = pts.size();
        per   = S + ((dw == 0) ? 1 : dw);
        total = np * per + 1;
        if (abort_k == -2)  abort_k  = $urandom_range(1, np * per);
        if (rst_k == -2)    rst_k    = $urandom_range(1, np * per);
        if (xstart_k == -2) xstart_k = $urandom_range(1, np * per);
        $display("sweep %s: f_start=%0d f_stop=%0d f_step=%0d dwell=%0d points=%0d abort@%0d rst@%0d",
                 name, fs, fstop, fstep, dw, np, abort_k, rst_k);

        f_start = 16'(fs); f_stop = 16'(fstop); f_step = 16'(fstep);
        vpp_set = 16'(vp); dwell = DW'(dw);
        start = 1'b1; abort = 1'b0; rst = 1'b0;
        hold_f = 0; hold_v = 0; hold_i = 0;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            fin = 1'b0;
            if (rst_k > 0 && k == rst_k + 1) begin
                chk_all({name, ".rst"}, k, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
                hold_f = 0; hold_v = 0; hold_i = 0;
                fin = 1'b1;
            end else if (abort_k > 0 && k == abort_k + 1) begin
                p = (abort_k - 1) / per;
                chk_all({name, ".abort"}, k, pts[p], vp, 0, 0, 0, 0, 0, 0, 1'b0);
                hold_f = pts[p]; hold_v = vp; hold_i = -1;
                fin = 1'b1;
            end else if (k == total) begin
                chk_all({name, ".done"}, k, pts[np-1], vp, 0, 0, 1, 0, 0, np - 1, 1'b1);
                hold_f = pts[np-1]; hold_v = vp; hold_i = np - 1;
                fin = 1'b1;
            end else begin
                p = (k - 1) / per;
                n = (k - 1) % per;
                chk_all({name, ".run"}, k, pts[p], vp, 1, 1, 0, int'(n == S), int'(n >= S), p, 1'b1);
            end
            if (fin) begin
                start = 1'b0; abort = 1'b0; rst = 1'b0;
                break;
            end
            // scramble configuration inputs: the latched copy must be unaffected
            f_start = 16'($urandom); f_stop = 16'($urandom); f_step = 16'($urandom);
            vpp_set = 16'($urandom); dwell = DW'($urandom_range(0, 7));
            start = (k == xstart_k);
            abort = (k == abort_k);
            rst   = (k == rst_k);
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk_all({name, ".idle"}, total + j, hold_f, hold_v, 0, 0, 0, 0, 0,
                    hold_i, hold_i >= 0);
        end
    endtask

    initial begin
        int fs, fst, fsp, mode, ak, rk;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; vpp_set = '0; dwell = '0;
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        // abort while idle must not start anything
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk_all("idle_abort", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);

        run_sweep("normal",    50,    80,    10, 50, 3, -1, -1, -1);
        run_sweep("unaligned", 50,    75,    10, 50, 3, -1, -1, -1);
        run_sweep("overflow",  65530, 65535, 10, 77, 2, -1, -1, -1);
        run_sweep("step0",     1234,  9000,  0,  5,  0, -1, -1, -1);
        run_sweep("revrange",  900,   100,   10, 9,  1, -1, -1, -1);
        run_sweep("abort",     50,    80,    10, 50, 3, 7 + S + 2, -1, 3);
        run_sweep("reset",     50,    80,    10, 50, 3, -1, 2 * 7 + 2, -1);
        run_sweep("restart",   50,    80,    10, 50, 3, -1, -1, 9);

        for (int i = 0; i < 25; i++) begin
            fs  = int'($urandom_range(0, 65535));
            fsp = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20000));
            if ($urandom_range(0, 5) == 0 && fs > 0) fst = int'($urandom_range(0, fs - 1));
            else fst = fs + fsp * int'($urandom_range(0, 6)) + int'($urandom_range(0, fsp));
            if (fst > 65535) fst = 65535;
            mode = int'($urandom_range(0, 5));
            ak = (mode == 0) ? -2 : -1;
            rk = (mode == 1) ? -2 : -1;
            run_sweep($sformatf("rand%0d", i), fs, fst, fsp, int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 5)), ak, rk, ($urandom_range(0, 1) == 1) ? -2 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
